// File: rtl/vga_pkg.sv
// XGA 1024x768@60 timing constants and shared widths for the VGA source.
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic SYNC_POL = 1'b1;

  localparam int HCOUNT_W    = 12;
  localparam int FRAME_CNT_W = 8;

  localparam logic [11:0] RGB_BLACK = 12'h000;

  // A total must be reachable by a 12-bit counter and give at least two positions.
  function automatic bit fits_counter(input int total);
    return (total >= 2) && (total <= (1 << HCOUNT_W));
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-stream bundle shared by the timing source and the draw chain.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the raster: position counter plus
// registered blank/sync decoded from the position being written.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   TOTAL      = H_TOTAL,
  parameter int   ACTIVE     = H_ACTIVE,
  parameter int   SYNC_START = H_SYNC_START,
  parameter int   SYNC_END   = H_SYNC_END,
  parameter logic POL        = SYNC_POL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                wrap_in,
  output logic [HCOUNT_W-1:0] cnt,
  output logic                blnk,
  output logic                sync,
  output logic                wrap_out
);

  if (!fits_counter(TOTAL)) begin : g_total_check
    $error("vga_axis_counter: TOTAL=%0d does not fit a %0d-bit counter", TOTAL, HCOUNT_W);
  end

  // Decode limits kept one bit wider so an end value of 4096 stays exact.
  localparam logic [HCOUNT_W-1:0] LAST     = HCOUNT_W'(TOTAL - 1);
  localparam logic [HCOUNT_W:0]   ACT_LIM  = (HCOUNT_W+1)'(ACTIVE);
  localparam logic [HCOUNT_W:0]   SYNC_LO  = (HCOUNT_W+1)'(SYNC_START);
  localparam logic [HCOUNT_W:0]   SYNC_HI  = (HCOUNT_W+1)'(SYNC_END);

  logic                step;
  logic                at_last;
  logic [HCOUNT_W-1:0] cnt_next;
  logic [HCOUNT_W:0]   cnt_next_ext;

  // Next position: advance only when enabled and the faster axis wraps.
  always_comb begin
    step         = ce & wrap_in;
    at_last      = (cnt == LAST);
    wrap_out     = step & at_last;
    cnt_next     = cnt;
    if (step) begin
      cnt_next = at_last ? '0 : cnt + 1'b1;
    end
    cnt_next_ext = {1'b0, cnt_next};
  end

  // Position, blank and sync all register from the same next position.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      blnk <= 1'b0;
      sync <= ~POL;
    end else if (step) begin
      cnt  <= cnt_next;
      blnk <= (cnt_next_ext >= ACT_LIM);
      sync <= ((cnt_next_ext >= SYNC_LO) && (cnt_next_ext < SYNC_HI)) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the draw chain: raster timing for vga_if plus frame pulse/counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACT    = H_ACTIVE,
  parameter int   H_FPORCH = H_FP,
  parameter int   H_SW     = H_SYNC,
  parameter int   H_BPORCH = H_BP,
  parameter int   V_ACT    = V_ACTIVE,
  parameter int   V_FPORCH = V_FP,
  parameter int   V_SW     = V_SYNC,
  parameter int   V_BPORCH = V_BP,
  parameter logic POL      = SYNC_POL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  vga_if.out                     vga_out,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int HT = H_ACT + H_FPORCH + H_SW + H_BPORCH;
  localparam int VT = V_ACT + V_FPORCH + V_SW + V_BPORCH;

  logic [HCOUNT_W-1:0] h_cnt;
  logic [HCOUNT_W-1:0] v_cnt;
  logic                h_blnk, h_sync, h_wrap;
  logic                v_blnk, v_sync, v_wrap;

  vga_axis_counter #(
    .TOTAL      (HT),
    .ACTIVE     (H_ACT),
    .SYNC_START (H_ACT + H_FPORCH),
    .SYNC_END   (H_ACT + H_FPORCH + H_SW),
    .POL        (POL)
  ) u_h (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .wrap_in  (1'b1),
    .cnt      (h_cnt),
    .blnk     (h_blnk),
    .sync     (h_sync),
    .wrap_out (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL      (VT),
    .ACTIVE     (V_ACT),
    .SYNC_START (V_ACT + V_FPORCH),
    .SYNC_END   (V_ACT + V_FPORCH + V_SW),
    .POL        (POL)
  ) u_v (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .wrap_in  (h_wrap),
    .cnt      (v_cnt),
    .blnk     (v_blnk),
    .sync     (v_sync),
    .wrap_out (v_wrap)
  );

  assign vga_out.hcount = h_cnt;
  assign vga_out.vcount = v_cnt;
  assign vga_out.hsync  = h_sync;
  assign vga_out.vsync  = v_sync;
  assign vga_out.hblnk  = h_blnk;
  assign vga_out.vblnk  = v_blnk;
  assign vga_out.rgb    = RGB_BLACK;

  // The vertical wrap fires only on the enabled edge leaving the last pixel,
  // so reset release and held cycles never produce a frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= v_wrap;
      if (v_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full XGA instance plus a reduced-timing instance
// so whole frames and the frame counter wrap fit in a short run.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int S_HA = 10, S_HF = 2, S_HS = 2, S_HB = 2;
  localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_FRAME = 160;

  localparam int HA_T[2] = '{H_ACTIVE, S_HA};
  localparam int HF_T[2] = '{H_FP,     S_HF};
  localparam int HS_T[2] = '{H_SYNC,   S_HS};
  localparam int HT_T[2] = '{H_TOTAL,  S_HA + S_HF + S_HS + S_HB};
  localparam int VA_T[2] = '{V_ACTIVE, S_VA};
  localparam int VF_T[2] = '{V_FP,     S_VF};
  localparam int VS_T[2] = '{V_SYNC,   S_VS};
  localparam int VT_T[2] = '{V_TOTAL,  S_VA + S_VF + S_VS + S_VB};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;
  logic       fs_x, fs_s;
  logic [7:0] fc_x, fc_s;

  vga_if vif_x ();
  vga_if vif_s ();

  int checks = 0;
  int errors = 0;

  vga_timing_gen dut_x (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .vga_out     (vif_x),
    .frame_start (fs_x),
    .frame_cnt   (fc_x)
  );

  vga_timing_gen #(
    .H_ACT (S_HA), .H_FPORCH (S_HF), .H_SW (S_HS), .H_BPORCH (S_HB),
    .V_ACT (S_VA), .V_FPORCH (S_VF), .V_SW (S_VS), .V_BPORCH (S_VB),
    .POL   (1'b1)
  ) dut_s (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .vga_out     (vif_s),
    .frame_start (fs_s),
    .frame_cnt   (fc_s)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: each instance is a linear pixel index within the frame.
  int m_pos[2];
  int m_fcnt[2];
  bit m_fs[2];
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pos[k]  = 0;
        m_fcnt[k] = 0;
        m_fs[k]   = 1'b0;
      end else if (ce) begin
        m_pos[k] = (m_pos[k] + 1) % (HT_T[k] * VT_T[k]);
        m_fs[k]  = (m_pos[k] == 0);
        if (m_fs[k]) m_fcnt[k] = (m_fcnt[k] + 1) % 256;
      end else begin
        m_fs[k] = 1'b0;
      end
    end
    if (rst) model_valid = 1'b1;
  end

  task automatic compare_dut(input int k, input string tag,
                             input int hc, input int vc, input int hs, input int vs,
                             input int hb, input int vb, input int rgb,
                             input int fs, input int fc);
    int h, v;
    h = m_pos[k] % HT_T[k];
    v = m_pos[k] / HT_T[k];
    checkOutput({tag, " hcount"}, hc, h);
    checkOutput({tag, " vcount"}, vc, v);
    checkOutput({tag, " hblnk"}, hb, int'(h >= HA_T[k]));
    checkOutput({tag, " vblnk"}, vb, int'(v >= VA_T[k]));
    checkOutput({tag, " hsync"}, hs,
                int'(h >= HA_T[k] + HF_T[k] && h < HA_T[k] + HF_T[k] + HS_T[k]));
    checkOutput({tag, " vsync"}, vs,
                int'(v >= VA_T[k] + VF_T[k] && v < VA_T[k] + VF_T[k] + VS_T[k]));
    checkOutput({tag, " rgb"}, rgb, 0);
    checkOutput({tag, " frame_start"}, fs, int'(m_fs[k]));
    checkOutput({tag, " frame_cnt"}, fc, m_fcnt[k]);
  endtask

  // Every-cycle comparison on the falling edge, once a reset has been seen.
  always @(negedge clk) begin
    if (model_valid) begin
      compare_dut(0, "xga", int'(vif_x.hcount), int'(vif_x.vcount), int'(vif_x.hsync),
                  int'(vif_x.vsync), int'(vif_x.hblnk), int'(vif_x.vblnk),
                  int'(vif_x.rgb), int'(fs_x), int'(fc_x));
      compare_dut(1, "small", int'(vif_s.hcount), int'(vif_s.vcount), int'(vif_s.hsync),
                  int'(vif_s.vsync), int'(vif_s.hblnk), int'(vif_s.vblnk),
                  int'(vif_s.rgb), int'(fs_s), int'(fc_s));
    end
  end

  task automatic applyStimulus(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    #1;
  endtask

  // Stimulus sequence with hand-computed pins on key positions.
  initial begin
    #1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset hcount", int'(vif_x.hcount), 0);
    checkOutput("reset vcount", int'(vif_x.vcount), 0);
    checkOutput("reset hsync", int'(vif_x.hsync), 0);
    checkOutput("reset vsync", int'(vif_x.vsync), 0);
    checkOutput("reset hblnk", int'(vif_x.hblnk), 0);
    checkOutput("reset frame_cnt", int'(fc_x), 0);

    applyStimulus(1'b0, 1'b1);
    checkOutput("release hcount", int'(vif_x.hcount), 1);
    checkOutput("release vcount", int'(vif_x.vcount), 0);
    checkOutput("release frame_start", int'(fs_x), 0);

    for (int n = 2; n <= 1344; n++) begin
      applyStimulus(1'b0, 1'b1);
      case (n)
        1023: checkOutput("xga hblnk@1023", int'(vif_x.hblnk), 0);
        1024: checkOutput("xga hblnk@1024", int'(vif_x.hblnk), 1);
        1047: checkOutput("xga hsync@1047", int'(vif_x.hsync), 0);
        1048: checkOutput("xga hsync@1048", int'(vif_x.hsync), 1);
        1183: checkOutput("xga hsync@1183", int'(vif_x.hsync), 1);
        1184: checkOutput("xga hsync@1184", int'(vif_x.hsync), 0);
        1344: begin
          checkOutput("xga line wrap hcount", int'(vif_x.hcount), 0);
          checkOutput("xga line wrap vcount", int'(vif_x.vcount), 1);
          checkOutput("xga line wrap hblnk", int'(vif_x.hblnk), 0);
        end
        12:  checkOutput("small hsync@h12", int'(vif_s.hsync), 1);
        14:  checkOutput("small hsync@h14", int'(vif_s.hsync), 0);
        95:  checkOutput("small vblnk@v5", int'(vif_s.vblnk), 0);
        96:  checkOutput("small vblnk@v6", int'(vif_s.vblnk), 1);
        111: checkOutput("small vsync@v6", int'(vif_s.vsync), 0);
        112: checkOutput("small vsync@v7", int'(vif_s.vsync), 1);
        160: begin
          checkOutput("small frame_start@wrap", int'(fs_s), 1);
          checkOutput("small frame_cnt@wrap", int'(fc_s), 1);
        end
        161: checkOutput("small frame_start after", int'(fs_s), 0);
        default: ;
      endcase
    end

    // 3 cycles enabled, 2 held.
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 5; j++) applyStimulus(1'b0, (j < 3));
      if (i == 0) checkOutput("xga hcount after 3on/2off", int'(vif_x.hcount), 3);
    end
    checkOutput("xga hcount after toggling", int'(vif_x.hcount), 600);
    checkOutput("small hcount after toggling", int'(vif_s.hcount), 8);

    for (int i = 0; i < 3000; i++) applyStimulus(1'b0, ($urandom_range(3, 0) != 0));

    applyStimulus(1'b1, 1'b1);
    checkOutput("midframe reset hcount", int'(vif_s.hcount), 0);
    checkOutput("midframe reset vcount", int'(vif_s.vcount), 0);
    checkOutput("midframe reset frame_cnt", int'(fc_s), 0);
    checkOutput("midframe reset frame_start", int'(fs_s), 0);
    checkOutput("midframe reset xga hcount", int'(vif_x.hcount), 0);

    for (int n = 1; n <= 256 * S_FRAME; n++) begin
      applyStimulus(1'b0, 1'b1);
      if (n == 255 * S_FRAME) checkOutput("small frame_cnt 255", int'(fc_s), 255);
      if (n == 256 * S_FRAME - 1) checkOutput("small frame_start pre-wrap", int'(fs_s), 0);
      if (n == 256 * S_FRAME) begin
        checkOutput("small frame_cnt wrap", int'(fc_s), 0);
        checkOutput("small frame_start 256th", int'(fs_s), 1);
      end
    end

    applyStimulus(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
